// File: rtl/line_pkg.sv
// -----------------------------------------------------------------------------
// line_pkg
// Shared definitions for the line interpolator:
//   XW_DEF / YW_DEF : default coordinate widths
//   X_MAX / Y_MAX   : last visible column / row of the 640x480 raster
//   err_width()     : signed width of the Bresenham error term, max(XW,YW)+2
//   ERR_W           : error-term width for the default coordinate widths
//   state_e         : interpolator FSM states
// -----------------------------------------------------------------------------
package line_pkg;

  localparam int XW_DEF = 10;
  localparam int YW_DEF = 10;
  localparam int X_MAX  = 639;
  localparam int Y_MAX  = 479;

  // Two extra bits hold the sign plus the doubled error (e2 = 2*err) headroom.
  function automatic int err_width(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

  localparam int ERR_W = err_width(XW_DEF, YW_DEF);

  typedef enum logic [1:0] {
    IDLE,   // no previous point
    HOLD,   // previous point held, nothing to draw
    SETUP,  // compute deltas and first step
    DRAW    // emit pixels
  } state_e;

endpackage

// File: rtl/line_step.sv
// -----------------------------------------------------------------------------
// line_step
// Purely combinational single Bresenham step.
//   x_i, y_i   : current point
//   err_i      : current error term (signed)
//   dx_i, dy_i : |x1-x0| and -|y1-y0| (signed)
//   sx_i, sy_i : step direction, 1 = toward the smaller coordinate
//   xe_i, ye_i : line endpoint
//   x_o, y_o   : next point
//   err_o      : next error term
//   last_o     : the current point (x_i,y_i) is the endpoint
// -----------------------------------------------------------------------------
module line_step
  import line_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF,
  parameter int EW = err_width(XW_DEF, YW_DEF)
) (
  input  logic [XW-1:0]        x_i,
  input  logic [YW-1:0]        y_i,
  input  logic signed [EW-1:0] err_i,
  input  logic signed [EW-1:0] dx_i,
  input  logic signed [EW-1:0] dy_i,
  input  logic                 sx_i,
  input  logic                 sy_i,
  input  logic [XW-1:0]        xe_i,
  input  logic [YW-1:0]        ye_i,
  output logic [XW-1:0]        x_o,
  output logic [YW-1:0]        y_o,
  output logic signed [EW-1:0] err_o,
  output logic                 last_o
);

  logic signed [EW:0] e2;
  logic signed [EW:0] dx_w;
  logic signed [EW:0] dy_w;
  logic               step_x;
  logic               step_y;

  assign e2   = {err_i, 1'b0};
  assign dx_w = {dx_i[EW-1], dx_i};
  assign dy_w = {dy_i[EW-1], dy_i};

  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);

  assign x_o = !step_x ? x_i : (sx_i ? x_i - 1'b1 : x_i + 1'b1);
  assign y_o = !step_y ? y_i : (sy_i ? y_i - 1'b1 : y_i + 1'b1);

  assign err_o = err_i + (step_x ? dy_i : '0) + (step_y ? dx_i : '0);

  assign last_o = (x_i == xe_i) && (y_i == ye_i);

endmodule

// File: rtl/line_interp.sv
// -----------------------------------------------------------------------------
// line_interp
// Turns sparse camera points into a contiguous stroke by walking a Bresenham
// line from the previous point to each new one, one pixel per handshake.
//   clk        : vga_clk domain clock
//   reset      : asynchronous, active-low reset
//   in_x/in_y  : mapped camera coordinate
//   in_valid   : level, pen visible
//   in_strobe  : one-cycle pulse, new sample on in_x/in_y
//   out_x/out_y: pixel to paint
//   out_valid  : pixel available
//   out_ready  : consumer accepts the pixel this cycle
//   busy       : high in SETUP or DRAW
//   overrun    : one-cycle pulse when the pending sample is overwritten
// Optional feature macro: THICK_PEN_EN -- each step is emitted as (x,y) and
// (x,y+1); the lower pixel is skipped on row Y_MAX.
// -----------------------------------------------------------------------------
module line_interp
  import line_pkg::*;
#(
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int MAX_JUMP = 96,
  parameter int Y_MAX    = line_pkg::Y_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  input  logic          in_valid,
  input  logic          in_strobe,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          overrun
);

  localparam int EW = err_width(XW, YW);

  state_e               state_q, state_d;
  logic                 pend_v_q, pend_v_d;
  logic [XW-1:0]        pend_x_q, pend_x_d;
  logic [YW-1:0]        pend_y_q, pend_y_d;
  logic [XW-1:0]        px_q, px_d, ex_q, ex_d, cx_q, cx_d;
  logic [YW-1:0]        py_q, py_d, ey_q, ey_d, cy_q, cy_d;
  logic signed [EW-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic                 sx_q, sx_d, sy_q, sy_d;
  logic                 lift_q, lift_d;
  logic                 overrun_q, overrun_d;
`ifdef THICK_PEN_EN
  logic                 second_q, second_d;
`endif

  // Jump / duplicate classification of the pending sample against P.
  logic [XW-1:0] adx_p, adx_e;
  logic [YW-1:0] ady_p, ady_e;
  logic          jump, same;

  assign adx_p = (pend_x_q > px_q) ? pend_x_q - px_q : px_q - pend_x_q;
  assign ady_p = (pend_y_q > py_q) ? pend_y_q - py_q : py_q - pend_y_q;
  assign adx_e = (ex_q > px_q) ? ex_q - px_q : px_q - ex_q;
  assign ady_e = (ey_q > py_q) ? ey_q - py_q : py_q - ey_q;
  assign jump  = (adx_p > XW'(MAX_JUMP)) || (ady_p > YW'(MAX_JUMP));
  assign same  = (pend_x_q == px_q) && (pend_y_q == py_q);

  // One stepper serves both the SETUP first step (from P with fresh deltas)
  // and every DRAW step (from the current point with registered deltas).
  logic                 in_setup;
  logic signed [EW-1:0] set_dx, set_dy;
  logic [XW-1:0]        nx;
  logic [YW-1:0]        ny;
  logic signed [EW-1:0] nerr;
  logic                 at_end;

  assign in_setup = (state_q == SETUP);
  assign set_dx   = EW'(adx_e);
  assign set_dy   = -EW'(ady_e);

  line_step #(.XW(XW), .YW(YW), .EW(EW)) u_step (
    .x_i   (in_setup ? px_q : cx_q),
    .y_i   (in_setup ? py_q : cy_q),
    .err_i (in_setup ? set_dx + set_dy : err_q),
    .dx_i  (in_setup ? set_dx : dx_q),
    .dy_i  (in_setup ? set_dy : dy_q),
    .sx_i  (in_setup ? !(ex_q > px_q) : sx_q),
    .sy_i  (in_setup ? !(ey_q > py_q) : sy_q),
    .xe_i  (ex_q),
    .ye_i  (ey_q),
    .x_o   (nx),
    .y_o   (ny),
    .err_o (nerr),
    .last_o(at_end)
  );

  // NOTE: async reset in the sensitivity list, and non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_v_q  <= 1'b0;
      pend_x_q  <= '0;
      pend_y_q  <= '0;
      px_q      <= '0;
      py_q      <= '0;
      ex_q      <= '0;
      ey_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      err_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      lift_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef THICK_PEN_EN
      second_q  <= 1'b0;
`endif
    end else begin
      pend_v_q  <= pend_v_d;
      pend_x_q  <= pend_x_d;
      pend_y_q  <= pend_y_d;
      px_q      <= px_d;
      py_q      <= py_d;
      ex_q      <= ex_d;
      ey_q      <= ey_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      err_q     <= err_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      lift_q    <= lift_d;
      overrun_q <= overrun_d;
`ifdef THICK_PEN_EN
      second_q  <= second_d;
`endif
    end
  end

  logic consume, start_single, advance;

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pend_v_d     = pend_v_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    px_d         = px_q;
    py_d         = py_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    err_d        = err_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    lift_d       = lift_q;
    overrun_d    = 1'b0;
`ifdef THICK_PEN_EN
    second_d     = second_q;
`endif
    consume      = 1'b0;
    start_single = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          consume      = 1'b1;
          start_single = 1'b1;
        end
      end
      HOLD: begin
        if (!in_valid) begin
          state_d = IDLE;
        end else if (pend_v_q) begin
          consume = 1'b1;
          if (jump) begin
            start_single = 1'b1;
          end else if (!same) begin
            ex_d    = pend_x_q;
            ey_d    = pend_y_q;
            lift_d  = 1'b0;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        dx_d    = set_dx;
        dy_d    = set_dy;
        sx_d    = !(ex_q > px_q);
        sy_d    = !(ey_q > py_q);
        cx_d    = nx;
        cy_d    = ny;
        err_d   = nerr;
        lift_d  = lift_q | !in_valid;
        state_d = DRAW;
      end
      DRAW: begin
        lift_d = lift_q | !in_valid;
        if (out_ready) begin
`ifdef THICK_PEN_EN
          if (!second_q && (cy_q != YW'(Y_MAX))) begin
            second_d = 1'b1;
          end else begin
            second_d = 1'b0;
            advance  = 1'b1;
          end
`else
          advance = 1'b1;
`endif
        end
        if (advance) begin
          if (at_end) begin
            px_d    = ex_q;
            py_d    = ey_q;
            state_d = (lift_q || !in_valid) ? IDLE : HOLD;
          end else begin
            cx_d  = nx;
            cy_d  = ny;
            err_d = nerr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A single-pixel stroke is a degenerate line whose start is its end.
    if (start_single) begin
      cx_d    = pend_x_q;
      cy_d    = pend_y_q;
      ex_d    = pend_x_q;
      ey_d    = pend_y_q;
      px_d    = pend_x_q;
      py_d    = pend_y_q;
      lift_d  = !in_valid;
      state_d = DRAW;
    end

    // A sample that lands in the same cycle the slot is drained replaces
    // nothing, so it does not count as an overrun.
    if (in_strobe && in_valid) begin
      pend_v_d  = 1'b1;
      pend_x_d  = in_x;
      pend_y_d  = in_y;
      overrun_d = pend_v_q && !consume;
    end else if (consume) begin
      pend_v_d  = 1'b0;
    end
  end

  always_comb begin
    out_valid = (state_q == DRAW);
    busy      = (state_q == SETUP) || (state_q == DRAW);
    out_x     = cx_q;
`ifdef THICK_PEN_EN
    out_y     = cy_q + YW'(second_q);
`else
    out_y     = cy_q;
`endif
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_line_interp.sv
// -----------------------------------------------------------------------------
// tb_line_interp
// Directed bench for line_interp: each scenario task drives stimulus and
// compares the accepted pixel stream, latency and status outputs against
// hand-computed values. Honours THICK_PEN_EN for the expected pixel lists.
// -----------------------------------------------------------------------------
module tb_line_interp;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] in_x, in_y;
  logic       in_valid, in_strobe;
  logic [9:0] out_x, out_y;
  logic       out_valid, out_ready, busy, overrun;

  always #5 clk = ~clk;

  line_interp dut (
    .clk      (clk),
    .reset    (reset),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_valid (in_valid),
    .in_strobe(in_strobe),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int first_valid = -1;
  int ovr_cnt = 0;
  int got_x[$], got_y[$], exp_x[$], exp_y[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are stable between posedge+1 and the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        got_x.push_back(int'(out_x));
        got_y.push_back(int'(out_y));
      end
      if (overrun) ovr_cnt++;
      if (out_valid && first_valid < 0) first_valid = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    got_x.delete(); got_y.delete();
    exp_x.delete(); exp_y.delete();
    first_valid = -1;
    ovr_cnt     = 0;
  endtask

  // Expected pixel for one Bresenham step, doubled when the thick pen is on.
  task automatic add_px(input int x, input int y);
    exp_x.push_back(x); exp_y.push_back(y);
`ifdef THICK_PEN_EN
    if (y != 479) begin
      exp_x.push_back(x); exp_y.push_back(y + 1);
    end
`endif
  endtask

  task automatic strobe(input int x, input int y);
    in_x      = 10'(x);
    in_y      = 10'(y);
    in_strobe = 1'b1;
    tick(1);
    in_strobe = 1'b0;
    strobe_cyc = cyc;
  endtask

  task automatic wait_quiet(input string name);
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 4; i++) begin
      tick(1);
      if (!busy && !out_valid) quiet++;
      else                     quiet = 0;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL %s_timeout: interpolator still active after 400 cycles", name);
    end
  endtask

  function automatic int first_diff();
    int n = (got_x.size() > exp_x.size()) ? got_x.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      if (i >= got_x.size() || i >= exp_x.size()) return i;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) return i;
    end
    return -1;
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check_stroke(input string name);
    int d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL %s: pixel %0d got (%0d,%0d) of %0d pixels, required (%0d,%0d) of %0d pixels",
               name, d, at(got_x, d), at(got_y, d), got_x.size(),
               at(exp_x, d), at(exp_y, d), exp_x.size());
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_strobe = 1'b0;
    in_valid  = 1'b1;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    in_x = 10'd77; in_y = 10'd33; in_valid = 1'b1; in_strobe = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_x !== 10'd0)    begin errors++; $display("FAIL reset_out_x: got %0d required 0", out_x); end
    checks++; if (out_y !== 10'd0)    begin errors++; $display("FAIL reset_out_y: got %0d required 0", out_y); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    do_reset();
  endtask

  task automatic test_single();
    clear();
    strobe(100, 100);
    wait_quiet("single");
    add_px(100, 100);
    check_stroke("single_pixel");
    checks++; if (first_valid - strobe_cyc != 1) begin errors++; $display("FAIL single_latency: got %0d required 1", first_valid - strobe_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_line();
    clear();
    strobe(105, 102);
    wait_quiet("line");
    add_px(101, 100); add_px(102, 101); add_px(103, 101); add_px(104, 102); add_px(105, 102);
    check_stroke("line_5px");
    checks++; if (first_valid - strobe_cyc != 2) begin errors++; $display("FAIL line_latency: got %0d required 2", first_valid - strobe_cyc); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL line_overrun: got %0d required 0", ovr_cnt); end
  endtask

  task automatic test_jump();
    do_reset();
    strobe(10, 10);
    wait_quiet("jump_start");
    clear();
    strobe(300, 10);
    wait_quiet("jump");
    add_px(300, 10);
    check_stroke("jump_single");
    checks++; if (first_valid - strobe_cyc != 1) begin errors++; $display("FAIL jump_latency: got %0d required 1", first_valid - strobe_cyc); end
    clear();
    strobe(300, 10);
    wait_quiet("dup");
    check_stroke("duplicate_no_output");
    clear();
    in_valid = 1'b0;
    strobe(310, 10);
    wait_quiet("invalid");
    in_valid = 1'b1;
    check_stroke("invalid_strobe_ignored");
  endtask

  task automatic test_stall();
    do_reset();
    strobe(0, 0);
    wait_quiet("stall_start");
    clear();
    out_ready = 1'b0;
    strobe(0, 20);
    tick(5);
    checks++; if (out_valid !== 1'b1 || out_x !== 10'd0 || out_y !== 10'd1) begin
      errors++; $display("FAIL stall_first_px: got v=%b (%0d,%0d) required v=1 (0,1)", out_valid, out_x, out_y);
    end
    strobe(5, 25);
    tick(10);
    strobe(6, 26);
    tick(32);
    checks++; if (out_valid !== 1'b1 || out_x !== 10'd0 || out_y !== 10'd1) begin
      errors++; $display("FAIL stall_frozen: got v=%b (%0d,%0d) required v=1 (0,1)", out_valid, out_x, out_y);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b required 1", busy); end
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL stall_overrun: got %0d pulses required 1", ovr_cnt); end
    checks++; if (got_x.size() != 0) begin errors++; $display("FAIL stall_no_accept: got %0d pixels required 0", got_x.size()); end
    out_ready = 1'b1;
    wait_quiet("stall");
    for (int i = 1; i <= 20; i++) add_px(0, i);
    for (int i = 1; i <= 6; i++)  add_px(i, 20 + i);
    check_stroke("stall_release");
  endtask

  task automatic test_pen_lift();
    clear();
    strobe(36, 26);
    tick(8);
    in_valid = 1'b0;
    tick(1);
    in_valid = 1'b1;
    strobe(50, 50);
    wait_quiet("lift");
    for (int i = 7; i <= 36; i++) add_px(i, 26);
    add_px(50, 50);
    check_stroke("pen_lift");
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lift_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    clear();
    strobe(53, 50);
    strobe(53, 53);
    wait_quiet("b2b");
    add_px(51, 50); add_px(52, 50); add_px(53, 50);
    add_px(53, 51); add_px(53, 52); add_px(53, 53);
    check_stroke("back_to_back");
  endtask

`ifdef THICK_PEN_EN
  task automatic test_thick();
    do_reset();
    strobe(50, 477);
    wait_quiet("thick_start");
    clear();
    strobe(52, 479);
    wait_quiet("thick");
    exp_x.push_back(51); exp_y.push_back(478);
    exp_x.push_back(51); exp_y.push_back(479);
    exp_x.push_back(52); exp_y.push_back(479);
    check_stroke("thick_bottom_edge");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_line();
    test_jump();
    test_stall();
    test_pen_lift();
    test_back_to_back();
`ifdef THICK_PEN_EN
    test_thick();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
